// File: rtl/mem_bus_arbiter_if.sv
// Request/ok memory bus bundle: CPU (m0) and DMA (m1) request ports, the shared memory port
// and arbiter status. The arbiter connects through the slave modport.
interface mem_bus_arbiter_if;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [1:0]  m0_width;
  logic        m0_read, m0_write, m0_ok;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [1:0]  m1_width;
  logic        m1_read, m1_write, m1_lock, m1_ok;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [1:0]  s_width;
  logic        s_read, s_write, s_ok;
  logic        owner, busy, err;

  modport slave (
    input  m0_addr, m0_wdata, m0_width, m0_read, m0_write,
    input  m1_addr, m1_wdata, m1_width, m1_read, m1_write, m1_lock,
    input  s_rdata, s_ok,
    output m0_rdata, m0_ok, m1_rdata, m1_ok,
    output s_addr, s_wdata, s_width, s_read, s_write,
    output owner, busy, err
  );

  modport master (
    output m0_addr, m0_wdata, m0_width, m0_read, m0_write,
    output m1_addr, m1_wdata, m1_width, m1_read, m1_write, m1_lock,
    output s_rdata, s_ok,
    input  m0_rdata, m0_ok, m1_rdata, m1_ok,
    input  s_addr, s_wdata, s_width, s_read, s_write,
    input  owner, busy, err
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU m0, DMA m1) arbiter for the single memory port, IDLE/BUSY request/ok protocol.
// Optional slave-ok watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int          ARB_MODE = 0,
  parameter logic [15:0] TIMEOUT  = 16'd1024
) (
  input  logic clk,
  input  logic rstn,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_grant_q, last_grant_d;
  logic   locked_q, locked_d;
  logic   req0, req1, own_req, done, tmo;

  if (TIMEOUT == 16'd0) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT must be non-zero");
  end

  assign req0    = bus.m0_read | bus.m0_write;
  assign req1    = bus.m1_read | bus.m1_write;
  assign own_req = owner_q ? req1 : req0;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // An owner that has already withdrawn is an abort, not a timeout.
  assign tmo = (state_q == BUSY) && !bus.s_ok && own_req && (cnt_q == TIMEOUT - 16'd1);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE)  cnt_d = 16'd0;
    else if (!bus.s_ok)   cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  assign done = (state_q == BUSY) && (bus.s_ok || tmo);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    locked_d     = locked_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = BUSY;
          if (locked_q && req1)   owner_d = 1'b1;
          else if (req0 && !req1) owner_d = 1'b0;
          else if (!req0 && req1) owner_d = 1'b1;
          else                    owner_d = (ARB_MODE == 0) ? 1'b1 : ~last_grant_q;
          if (!owner_d) locked_d = 1'b0;
        end
      end
      BUSY: begin
        if (done) begin
          state_d      = IDLE;
          last_grant_d = owner_q;
          locked_d     = owner_q & bus.m1_lock;
        end else if (!own_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A write wins when a master raises both strobes.
  always_comb begin
    bus.s_addr   = 32'h0;
    bus.s_wdata  = 32'h0;
    bus.s_width  = 2'd0;
    bus.s_read   = 1'b0;
    bus.s_write  = 1'b0;
    bus.m0_ok    = 1'b0;
    bus.m1_ok    = 1'b0;
    bus.m0_rdata = 32'h0;
    bus.m1_rdata = 32'h0;
    bus.busy     = (state_q == BUSY);
    bus.owner    = owner_q;
    bus.err      = tmo;
    if (state_q == BUSY) begin
      if (owner_q) begin
        bus.s_addr  = bus.m1_addr;
        bus.s_wdata = bus.m1_wdata;
        bus.s_width = bus.m1_width;
        bus.s_read  = bus.m1_read & ~bus.m1_write;
        bus.s_write = bus.m1_write;
      end else begin
        bus.s_addr  = bus.m0_addr;
        bus.s_wdata = bus.m0_wdata;
        bus.s_width = bus.m0_width;
        bus.s_read  = bus.m0_read & ~bus.m0_write;
        bus.s_write = bus.m0_write;
      end
    end
    if (done) begin
      if (owner_q) begin
        bus.m1_ok    = 1'b1;
        bus.m1_rdata = tmo ? 32'h0 : bus.s_rdata;
      end else begin
        bus.m0_ok    = 1'b1;
        bus.m0_rdata = tmo ? 32'h0 : bus.s_rdata;
      end
    end
  end

endmodule
